pmem_resp: RTL and testbench

PMEM_RESP -- requirements
Module: pmem_resp

---
 rtl/pmem_resp_pkg.sv | 30 +++
 rtl/pmem_array.sv | 40 ++++
 rtl/pmem_resp.sv | 161 ++++++++++++++++
 tb/tb_pmem_resp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pmem_resp_pkg.sv
// Shared types and constants for the pmem_resp responder and its storage.
//   state_e         : FSM state encoding (IDLE, WAIT, RESP)
//   LATENCY_DEFAULT : default accept-to-response latency in cycles
//   merge_bytes     : byte-enable merge of new data into an old word
package pmem_resp_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned MASK_W          = DATA_W / 8;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < int'(MASK_W); b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pmem_array.sv
// Word-addressed storage, 2^DEPTH_LOG2 x 32 bits, no reset.
//   clk     : clock
//   we_i    : write enable, bytes selected by wmask_i
//   wmask_i : byte enables for the write
//   addr_i  : word address shared by the read and write ports
//   wdata_i : write data
//   re_i    : read enable, registers mem[addr_i] into rdata_o
//   rdata_o : registered read data, holds between reads
module pmem_array
  import pmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [MASK_W-1:0]     wmask_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-enable write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= merge_bytes(mem_q[addr_i], wdata_i, wmask_i);
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_resp.sv
// Fixed-latency memory responder: accepts one request at a time, performs
// the storage access LATENCY cycles later and holds the response until the
// initiator takes it.
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready           : request handshake (ready only in IDLE)
//   req_wen/addr/wdata/wmask      : request payload, sampled on accept
//   resp_valid/resp_ready         : response handshake
//   resp_rdata                    : read data, 0 for writes, errors and idle
//   resp_err                      : address outside the stored range
module pmem_resp
  import pmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               wen_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MASK_W-1:0]  wmask_q;

  logic               resp_valid_q, resp_err_q, rd_sel_q;

  logic               accept, enter_resp, resp_done;
  logic               cur_wen, cur_oor;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_wdata;
  logic [MASK_W-1:0]  cur_wmask;
  logic [DATA_W-1:0]  arr_rdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM control outputs.
  always_comb begin
    req_ready  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    resp_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready  = !rst;
        accept     = !rst && req_valid;
        // With LATENCY=1 the access happens on the accept edge itself.
        enter_resp = !rst && req_valid && (LATENCY == 1);
      end
      WAIT:    enter_resp = !rst && (cnt_q == CNT_W'(1));
      RESP:    resp_done  = resp_ready;
      default: ;
    endcase
  end

  // Access uses the live request when it is accepted and accessed on the same edge.
  assign cur_wen   = (state_q == IDLE) ? req_wen   : wen_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_wmask = (state_q == IDLE) ? req_wmask : wmask_q;
  assign cur_oor   = (cur_addr >> DEPTH_LOG2) != '0;

  // Request latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  // Response registers; rd_sel_q gates the array output so idle/write/error read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
    end else if (enter_resp) begin
      resp_valid_q <= 1'b1;
      resp_err_q   <= cur_oor;
      rd_sel_q     <= !cur_wen && !cur_oor;
    end else if (resp_done) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
    end
  end

  pmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (enter_resp && cur_wen && !cur_oor),
    .wmask_i (cur_wmask),
    .addr_i  (cur_addr[DEPTH_LOG2-1:0]),
    .wdata_i (cur_wdata),
    .re_i    (enter_resp && !cur_wen && !cur_oor),
    .rdata_o (arr_rdata)
  );

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rd_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_pmem_resp.sv
// Bench for pmem_resp: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1.
// A cycle-level reference model predicts every output; directed tests add
// hand-computed literal expectations.
module tb_pmem_resp;

  localparam int DL2 = 10;
  localparam int LAT [2] = '{2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0, req_wen = '0, resp_ready = '0;
  logic [1:0]  req_ready, resp_valid, resp_err;
  logic [23:0] req_addr  [2] = '{default: '0};
  logic [31:0] req_wdata [2] = '{default: '0};
  logic [3:0]  req_wmask [2] = '{default: '0};
  logic [31:0] resp_rdata [2];

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pmem_resp #(.ADDR_W(24), .DEPTH_LOG2(DL2), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  pmem_resp #(.ADDR_W(24), .DEPTH_LOG2(DL2), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a transaction is outstanding from accept until its
  // response is taken; the access lands LATENCY cycles after the accept cycle.
  bit          m_busy [2], m_valid [2], m_err [2];
  bit   [31:0] m_rdata [2];
  int unsigned m_acc [2];
  bit          m_wen [2];
  bit   [23:0] m_addr [2];
  bit   [31:0] m_wdata [2];
  bit   [3:0]  m_wmask [2];
  bit   [31:0] mem_m [2][1 << DL2];
  int unsigned edge_n = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_valid[i] = 0; m_err[i] = 0; m_rdata[i] = 0;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          if (resp_ready[i]) begin
            m_valid[i] = 0; m_busy[i] = 0; m_err[i] = 0; m_rdata[i] = 0;
          end
        end else if (!m_busy[i] && req_valid[i]) begin
          m_busy[i] = 1; m_acc[i] = edge_n;
          m_wen[i] = req_wen[i]; m_addr[i] = req_addr[i];
          m_wdata[i] = req_wdata[i]; m_wmask[i] = req_wmask[i];
        end
        if (m_busy[i] && !m_valid[i] && edge_n == m_acc[i] + LAT[i] - 1) begin
          m_valid[i] = 1;
          m_rdata[i] = 0;
          m_err[i]   = (m_addr[i] >= (1 << DL2));
          if (!m_err[i]) begin
            if (m_wen[i]) begin
              for (int b = 0; b < 4; b++)
                if (m_wmask[i][b]) mem_m[i][m_addr[i][DL2-1:0]][8*b +: 8] = m_wdata[i][8*b +: 8];
            end else begin
              m_rdata[i] = mem_m[i][m_addr[i][DL2-1:0]];
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(!m_busy[i] && !rst));
      chk($sformatf("resp_valid[%0d]", i), 32'(resp_valid[i]), 32'(m_valid[i]));
      chk($sformatf("resp_rdata[%0d]", i), resp_rdata[i], m_rdata[i]);
      chk($sformatf("resp_err[%0d]", i), 32'(resp_err[i]), 32'(m_err[i]));
    end
  end

  // One transaction; hold = cycles resp_ready stays 0 after resp_valid.
  task automatic xact(input int i, input bit wen, input logic [23:0] addr,
                      input logic [31:0] wd, input logic [3:0] wm, input int hold,
                      output int lat, output logic [31:0] rd, output logic er);
    int t;
    @(negedge clk); #1;
    req_wen[i] = wen; req_addr[i] = addr; req_wdata[i] = wd; req_wmask[i] = wm;
    req_valid[i] = 1'b1; resp_ready[i] = 1'b0;
    t = 0;
    while (!req_ready[i] && t < 100) begin @(negedge clk); #1; t++; end
    if (t >= 100) chk("accept_timeout", 32'(req_ready[i]), 32'd1);
    @(posedge clk);
    @(negedge clk); #1;
    req_valid[i] = 1'b0; req_wen[i] = 1'($urandom);
    req_addr[i] = 24'($urandom); req_wdata[i] = $urandom; req_wmask[i] = 4'($urandom);
    lat = 1;
    while (!resp_valid[i] && lat < 40) begin @(negedge clk); #1; lat++; end
    if (lat >= 40) chk("resp_timeout", 32'(resp_valid[i]), 32'd1);
    rd = resp_rdata[i]; er = resp_err[i];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", 32'(resp_valid[i]), 32'd1);
      chk("bp_rdata", resp_rdata[i], rd);
      chk("bp_err", 32'(resp_err[i]), 32'(er));
      chk("bp_req_ready", 32'(req_ready[i]), 32'd0);
    end
    resp_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    resp_ready[i] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          acc_k [$];
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_resp_rdata", resp_rdata[0], 32'd0);
    chk("rst_resp_err", 32'(resp_err[0]), 32'd0);

    // Full-word write then read.
    xact(0, 1, 24'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rdata", rd, 32'd0);
    xact(0, 0, 24'h10, 32'h0, 4'h0, 0, lat, rd, er);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);

    // Byte-masked write.
    xact(0, 1, 24'h10, 32'h000000AA, 4'b0001, 0, lat, rd, er);
    xact(0, 0, 24'h10, 32'h0, 4'h0, 0, lat, rd, er);
    chk("mask_rdata", rd, 32'hDEADBEAA);

    // Zero-mask write leaves storage unchanged.
    xact(0, 1, 24'h10, 32'hFFFFFFFF, 4'b0000, 0, lat, rd, er);
    chk("m0_err", 32'(er), 32'd0);
    xact(0, 0, 24'h10, 32'h0, 4'h0, 0, lat, rd, er);
    chk("m0_rdata", rd, 32'hDEADBEAA);

    // Out-of-range accesses.
    xact(0, 1, 24'h0, 32'h11223344, 4'hF, 0, lat, rd, er);
    xact(0, 1, 24'h400, 32'h55667788, 4'hF, 0, lat, rd, er);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_rdata", rd, 32'd0);
    xact(0, 0, 24'h400, 32'h0, 4'h0, 0, lat, rd, er);
    chk("oor_rd_err", 32'(er), 32'd1);
    chk("oor_rd_rdata", rd, 32'd0);
    xact(0, 0, 24'h0, 32'h0, 4'h0, 0, lat, rd, er);
    chk("addr0_rdata", rd, 32'h11223344);

    // Backpressure: response held 5 cycles.
    xact(0, 0, 24'h10, 32'h0, 4'h0, 5, lat, rd, er);
    chk("bp_captured", rd, 32'hDEADBEAA);
    chk("bp_after_ready", 32'(req_ready[0]), 32'd1);
    chk("bp_after_valid", 32'(resp_valid[0]), 32'd0);

    // Reset during a pending write.
    xact(0, 1, 24'h20, 32'hCAFEF00D, 4'hF, 0, lat, rd, er);
    @(negedge clk); #1;
    req_wen[0] = 1'b1; req_addr[0] = 24'h20; req_wdata[0] = 32'h12345678;
    req_wmask[0] = 4'hF; req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0; rst = 1'b1;
    #1 chk("rst_mid_valid", 32'(resp_valid[0]), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    xact(0, 0, 24'h20, 32'h0, 4'h0, 0, lat, rd, er);
    chk("rst_mid_rdata", rd, 32'hCAFEF00D);

    // LATENCY=1 instance.
    xact(1, 1, 24'h5, 32'h0BADF00D, 4'hF, 0, lat, rd, er);
    chk("l1_wr_latency", 32'(lat), 32'd1);
    xact(1, 0, 24'h5, 32'h0, 4'h0, 0, lat, rd, er);
    chk("l1_rd_latency", 32'(lat), 32'd1);
    chk("l1_rd_rdata", rd, 32'h0BADF00D);

    // Back-to-back reads with resp_ready held: accepts every 2 cycles.
    @(negedge clk); #1;
    req_wen[1] = 1'b0; req_addr[1] = 24'h5; req_valid[1] = 1'b1; resp_ready[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (req_ready[1]) acc_k.push_back(k);
      @(negedge clk); #1;
    end
    req_valid[1] = 1'b0;
    chk("l1_accepts", 32'(acc_k.size()), 32'd4);
    for (int k = 1; k < acc_k.size(); k++)
      chk("l1_spacing", 32'(acc_k[k] - acc_k[k-1]), 32'd2);
    repeat (3) @(negedge clk);
    #1 resp_ready[1] = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
